// File: rtl/quet_led2.sv
// quet_led2 - two-digit time-multiplexed seven-segment driver.
//
// Lights one of two digits at a time on a shared, active-low segment bus.
// Each digit owns a slot of DIV clock cycles; the first BLANK cycles of a
// slot are dark so the previous digit's pattern never ghosts onto the next.
// The digit pattern is captured once, on the edge that enters the lit part
// of the slot, and held until the slot ends.
//
// Parameters:
//   DIV    slot length in clock cycles (>= 2)
//   BLANK  dark cycles at the start of each slot (1 <= BLANK < DIV)
//
// Ports:
//   i_ck   clock, rising edge
//   i_rs   synchronous active-high reset (priority over i_en)
//   i_en   scan enable; low forces dark and restarts the scan
//   i_d0   units digit segment pattern, active-low (bit7 = dp)
//   i_d1   tens digit segment pattern, active-low
//   o_seg  shared segment bus, active-low, registered
//   o_an   digit enables, active-low, [0] = units, [1] = tens, registered

module quet_led2 #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic       i_ck,
    input  logic       i_rs,
    input  logic       i_en,
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    output logic [7:0] o_seg,
    output logic [1:0] o_an
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [7:0]       r_seg;
    logic [1:0]       r_an;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sel_nxt;

    // Next-state slot position; the outputs are decoded from this so that the
    // wrap edge toggles the digit and blanks the bus in the same cycle.
    assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    assign w_sel_nxt = (r_cnt == LAST) ? ~r_sel : r_sel;

    always_ff @(posedge i_ck) begin
        if (i_rs || !i_en) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_seg <= 8'hFF;
            r_an  <= 2'b11;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sel <= w_sel_nxt;
            if (w_cnt_nxt < BLANK_C) begin
                r_seg <= 8'hFF;
                r_an  <= 2'b11;
            end else if (w_cnt_nxt == BLANK_C) begin
                // Single capture point per slot; later input changes are
                // ignored until the next slot opens.
                r_seg <= w_sel_nxt ? i_d1 : i_d0;
                r_an  <= w_sel_nxt ? 2'b01 : 2'b10;
            end
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule

// File: doc/quet_led2.md
# quet_led2

Two-digit time-multiplexed driver for a seven-segment display with shared segments. It sits directly downstream of the 0–15 counter's segment decoder and takes the decoder's two active-low segment patterns (units, tens). It drives one shared 8-bit segment bus plus two active-low digit enables, and lights one digit at a time. Each slot opens with a blanking interval to suppress ghosting between digits.

## Interface
- DIV, 50000: slot length in clock cycles per digit; legal DIV >= 2
- BLANK, 4: blanked cycles at the start of each slot; legal 1 <= BLANK < DIV
- ck  in  1  clock; all state updates on rising edge
- rs  in  1  reset; one clock; reset is synchronous and active-high
- en  in  1  scan enable; 0 forces display dark and restarts the scan
- d0  in  8  units digit segment pattern, active-low (bit7 = dp)
- d1  in  8  tens digit segment pattern, active-low
- seg  out  8  shared segment bus, active-low; registered
- an  out  2  digit enables, active-low; an[0] = units, an[1] = tens; registered

## Operation
- State registers:
  - cnt: slot counter, 0..DIV-1, width ceil(log2(DIV))
  - sel: current digit, 0 = units, 1 = tens
  - seg, an: output registers
- Slot phases, selected by sel and cnt:
  - BLANK0: sel=0, cnt < BLANK
  - SHOW0: sel=0, cnt >= BLANK
  - BLANK1: sel=1, cnt < BLANK
  - SHOW1: sel=1, cnt >= BLANK
  - Sequence cycles BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
- Counting, per rising edge with rs=0 and en=1:
  - If cnt == DIV-1: cnt <= 0 and sel <= ~sel.
  - Otherwise cnt <= cnt+1.
- Output loading on each edge, computed from the next-state values (cnt', sel'):
  - If cnt' < BLANK: seg <= 8'hFF, an <= 2'b11.
  - If cnt' == BLANK: seg <= (sel' ? d1 : d0). an <= 2'b01 when sel'=1, 2'b10 when sel'=0.
  - If cnt' > BLANK: seg and an hold. Input changes mid-SHOW are ignored until the next slot.
- en=0 on an edge (rs=0):
  - cnt <= 0, sel <= 0, seg <= 8'hFF, an <= 2'b11.
  - When en returns to 1, scan resumes exactly as after reset.
- Invariant: an is never 2'b00. seg equals 8'hFF whenever an == 2'b11.

## Timing
- Reset values: cnt=0, sel=0, seg=8'hFF, an=2'b11. rs has priority over en.
- Reset applied mid-SHOW: outputs go dark on that edge; no partial slot is retained.
- After the first edge with rs=0 and en=1, call it edge 1:
  - Digit 0 lights on edge BLANK.
  - Digit 0 goes dark on edge DIV.
  - Digit 1 lights on edge DIV+BLANK.
  - Frame period is 2*DIV cycles; each digit is lit DIV-BLANK cycles per frame.
- Input capture: d0/d1 are sampled only on the edge entering SHOW, 1-cycle latency to seg.
- Wrap: cnt DIV-1 -> 0 toggles sel on the same edge that blanks the outputs. There is no cycle in which the old digit's enable meets the new digit's pattern.
- en falling and cnt wrap on the same edge: en wins, giving cnt=0, sel=0, dark.

## Test plan
- Reset then en=1, d0=8'hC0, d1=8'hF9, DIV=8, BLANK=2:
  - seg=FF, an=11 after edges 0–1.
  - seg=C0, an=10 from edge 2 to 7.
  - seg=FF, an=11 at edges 8–9.
  - seg=F9, an=01 from edge 10 to 15.
  - Pattern repeats with period 16.
- Change d0 from C0 to A4 mid-SHOW0 (edge 4): seg stays C0 through edge 7; A4 appears at edge 18.
- en=0 at edge 12 (during SHOW1): edge 12 gives seg=FF, an=11. After en=1 again, digit 0 lights 2 edges later.
- Assert rs at edge 5 of a running scan: outputs FF/11 on that edge and while held. Release reproduces the first scenario's timeline.
- Boundary DIV=2, BLANK=1: each digit lit 1 cycle per 4-cycle frame. an is never 00 and seg is FF whenever an=11, checked over 100 cycles.
- Drive d0/d1 from the 0–15 counter's decoder, counter at 15 (d0=92, d1=F9): scan alternates 92 on an=10 and F9 on an=01.
